hpi_xfer_ctrl: RTL and testbench

Parametrised CY7C67200 HPI bus transaction engine, successor to the fixed single-access HPI I/O interface. Accepts read/write burst requests from the Nios-side PIO/glue logic and sequences the OTG_CS_N/RD_N/WR_N strobes with programmable setup/strobe/hold timing. Sits between the nios_system HPI exports and the OTG_* top-level pins, replacing per-access software bit-banging.

---
 rtl/hpi_xfer_ctrl_if.sv | 40 ++++
 rtl/hpi_xfer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hpi_xfer_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_xfer_ctrl_if.sv
// HPI transaction bus: request/data handshake toward the Nios glue logic and
// the OTG_* pin-side signals. The slave modport is the transaction engine's view.
interface hpi_xfer_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 2,
  parameter int MAX_BURST = 8
);
  localparam int LEN_W = $clog2(MAX_BURST + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] otg_addr;
  logic [DATA_W-1:0] otg_data_out;
  logic              otg_data_oe;
  logic [DATA_W-1:0] otg_data_in;
  logic              otg_cs_n;
  logic              otg_rd_n;
  logic              otg_wr_n;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, otg_data_in,
    output req_ready, wr_pop, rd_data, rd_valid, done, busy,
           otg_addr, otg_data_out, otg_data_oe, otg_cs_n, otg_rd_n, otg_wr_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, otg_data_in,
    input  req_ready, wr_pop, rd_data, rd_valid, done, busy,
           otg_addr, otg_data_out, otg_data_oe, otg_cs_n, otg_rd_n, otg_wr_n
  );
endinterface

// File: rtl/hpi_xfer_ctrl.sv
// CY7C67200 HPI burst engine: sequences CS_N/RD_N/WR_N with setup/strobe/hold timing.
// Optional macro HPI_BEAT_COUNT_EN adds a free-running completed-beat counter output.
module hpi_xfer_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  hpi_xfer_ctrl_if.slave bus
`ifdef HPI_BEAT_COUNT_EN
  ,
  output logic [31:0]    beat_count
`endif
);
  localparam int LEN_W   = $clog2(MAX_BURST + 1);
  localparam int SS_MAX  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_MAX = (SS_MAX > HOLD_CYC) ? SS_MAX : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]  eff_len;
  logic              beat_end;

  assign beat_end = (state_q == S_HOLD) && (cyc_q == HOLD_LAST);

  // Zero-length requests still move one beat; oversize requests are clipped.
  always_comb begin
    if (bus.req_len == '0)
      eff_len = LEN_W'(1);
    else if (bus.req_len > MAX_LEN)
      eff_len = MAX_LEN;
    else
      eff_len = bus.req_len;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      rem_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rdat_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      rem_q      <= rem_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rdat_q     <= rdat_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    rem_d      = rem_q;
    write_d    = write_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rdat_d     = rdat_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_SETUP;
          cyc_d   = '0;
          rem_d   = eff_len - LEN_W'(1);
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
        end
      end
      S_SETUP: begin
        if (write_q && cyc_q == '0)
          dout_d = bus.wr_data;
        if (cyc_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cyc_q == STROBE_LAST) begin
          state_d = S_HOLD;
          cyc_d   = '0;
          if (!write_q) begin
            rdat_d     = bus.otg_data_in;
            rd_valid_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (beat_end) begin
          cyc_d = '0;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            rem_d   = rem_q - LEN_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CS_N spans every beat of a burst; data is only driven once wr_data is registered.
  always_comb begin
    bus.req_ready    = (state_q == S_IDLE);
    bus.busy         = (state_q != S_IDLE);
    bus.done         = (state_q == S_DONE);
    bus.otg_cs_n     = !(state_q inside {S_SETUP, S_STROBE, S_HOLD});
    bus.otg_rd_n     = !((state_q == S_STROBE) && !write_q);
    bus.otg_wr_n     = !((state_q == S_STROBE) && write_q);
    bus.wr_pop       = (state_q == S_SETUP) && write_q && (cyc_q == '0);
    bus.otg_data_oe  = write_q && (((state_q == S_SETUP) && (cyc_q != '0)) ||
                                   (state_q == S_STROBE) || (state_q == S_HOLD));
    bus.otg_addr     = addr_q;
    bus.otg_data_out = dout_q;
    bus.rd_data      = rdat_q;
    bus.rd_valid     = rd_valid_q;
  end

`ifdef HPI_BEAT_COUNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb beat_cnt_d = beat_end ? beat_cnt_q + 32'd1 : beat_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) beat_cnt_q <= '0;
    else          beat_cnt_q <= beat_cnt_d;
  end

  assign beat_count = beat_cnt_q;
`endif
endmodule

// File: tb/tb_hpi_xfer_ctrl.sv
// Bench for hpi_xfer_ctrl: table of bursts checked through a pin-level scoreboard,
// plus hand-written timing, back-to-back request and mid-burst reset sequences.
module tb_hpi_xfer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hpi_xfer_ctrl_if #(.DATA_W(16), .ADDR_W(2), .MAX_BURST(8)) bus ();
`ifdef HPI_BEAT_COUNT_EN
  logic [31:0] beat_count;
`endif

  hpi_xfer_ctrl dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .bus        (bus)
`ifdef HPI_BEAT_COUNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [3:0]  len;
    int          beats;
    logic [15:0] base;
  } vec_t;

  vec_t vecs[7];
  int errors = 0;
  int checks = 0;

  logic [15:0] wr_src[$];
  logic [15:0] exp_wr[$];
  logic [15:0] rd_src[$];
  logic [15:0] exp_rd[$];
  logic [1:0]  exp_addr = '0;

  int beats = 0, done_cnt = 0, cs_low = 0, cs_rise = 0;
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin-level device model and scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.wr_data     = '0;
      bus.otg_data_in = '0;
    end else begin
      if (!bus.otg_cs_n) cs_low++;
      if (bus.otg_cs_n && !prev_cs) cs_rise++;
      if (!bus.otg_rd_n && prev_rd) begin
        beats++;
        chk("rd_addr", 32'(bus.otg_addr), 32'(exp_addr));
        chk("rd_oe", 32'(bus.otg_data_oe), 32'd0);
        bus.otg_data_in = (rd_src.size() > 0) ? rd_src.pop_front() : 16'hDEAD;
      end
      if (!bus.otg_wr_n && prev_wr) begin
        beats++;
        chk("wr_addr", 32'(bus.otg_addr), 32'(exp_addr));
        chk("wr_oe", 32'(bus.otg_data_oe), 32'd1);
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else chk("wr_data", 32'(bus.otg_data_out), 32'(exp_wr.pop_front()));
      end
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
      end
      if (bus.wr_pop) bus.wr_data = (wr_src.size() > 0) ? wr_src.pop_front() : 16'h0BAD;
      if (bus.done) done_cnt++;
    end
    prev_cs = bus.otg_cs_n;
    prev_rd = bus.otg_rd_n;
    prev_wr = bus.otg_wr_n;
  end

  task automatic push_exp(input bit wr, input logic [3:0] len, input logic [15:0] base);
    int eff;
    eff = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    for (int i = 0; i < eff; i++) begin
      logic [15:0] v;
      v = base + 16'(i * 16'h1111);
      if (wr) begin wr_src.push_back(v); exp_wr.push_back(v); end
      else    begin rd_src.push_back(v); exp_rd.push_back(v); end
    end
  endtask

  task automatic issue(input bit wr, input logic [1:0] addr, input logic [3:0] len);
    exp_addr      = addr;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_burst(input bit wr, input logic [1:0] addr, input logic [3:0] len,
                           input logic [15:0] base, input int beats_exp);
    int b0, d0, c0, r0;
    push_exp(wr, len, base);
    @(negedge clk);
    b0 = beats; d0 = done_cnt; c0 = cs_low; r0 = cs_rise;
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    issue(wr, addr, len);
    chk("busy_accept", 32'(bus.busy), 32'd1);
    wait_done(d0);
    @(posedge clk);
    #1;
    chk("beats", 32'(beats - b0), 32'(beats_exp));
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("cs_low_cycles", 32'(cs_low - c0), 32'(8 * beats_exp));
    chk("cs_rises", 32'(cs_rise - r0), 32'd1);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("idle_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m_cs, m_wr, m_done, m_oe, m_pop, m_rdy, m_busy;
    int d0, busy_seen;

    vecs[0] = '{1'b1, 2'd2, 4'd1,  1, 16'hBEEF};
    vecs[1] = '{1'b0, 2'd0, 4'd3,  3, 16'h1111};
    vecs[2] = '{1'b0, 2'd1, 4'd0,  1, 16'h0F0F};
    vecs[3] = '{1'b1, 2'd3, 4'd15, 8, 16'h1000};
    vecs[4] = '{1'b1, 2'd0, 4'd8,  8, 16'h2000};
    vecs[5] = '{1'b0, 2'd3, 4'd9,  8, 16'h3000};
    vecs[6] = '{1'b1, 2'd1, 4'd2,  2, 16'hFFFF};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(bus.otg_cs_n), 32'd1);
    chk("rst_rd_n", 32'(bus.otg_rd_n), 32'd1);
    chk("rst_wr_n", 32'(bus.otg_wr_n), 32'd1);
    chk("rst_oe", 32'(bus.otg_data_oe), 32'd0);
    chk("rst_addr", 32'(bus.otg_addr), 32'd0);
    chk("rst_dout", 32'(bus.otg_data_out), 32'd0);
    chk("rst_rdata", 32'(bus.rd_data), 32'd0);
    chk("rst_pulses", {29'd0, bus.rd_valid, bus.wr_pop, bus.done}, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].beats);

    // Cycle-accurate single write: cycle k is the k-th cycle after the accept edge.
    push_exp(1'b1, 4'd1, 16'hBEEF);
    @(negedge clk);
    issue(1'b1, 2'd2, 4'd1);
    m_cs = '0; m_wr = '0; m_done = '0; m_oe = '0; m_pop = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      m_cs[k]   = !bus.otg_cs_n;
      m_wr[k]   = !bus.otg_wr_n;
      m_done[k] = bus.done;
      m_oe[k]   = bus.otg_data_oe;
      m_pop[k]  = bus.wr_pop;
    end
    chk("t_cs_low", 32'(m_cs), 32'h01FE);
    chk("t_wr_low", 32'(m_wr), 32'h0078);
    chk("t_done", 32'(m_done), 32'h0200);
    chk("t_oe", 32'(m_oe), 32'h01FC);
    chk("t_wr_pop", 32'(m_pop), 32'h0002);
    chk("t_dout", 32'(bus.otg_data_out), 32'hBEEF);
    chk("t_addr_hold", 32'(bus.otg_addr), 32'd2);

    // req_valid held high: next accept only from IDLE after done.
    push_exp(1'b0, 4'd1, 16'hA5A5);
    push_exp(1'b0, 4'd1, 16'h5A5A);
    @(negedge clk);
    d0 = done_cnt;
    exp_addr = 2'd1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'd1;
    bus.req_len   = 4'd1;
    @(posedge clk);
    m_rdy = '0; m_busy = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      m_rdy[k]  = bus.req_ready;
      m_busy[k] = bus.busy;
      bus.req_write = 1'b1;
      bus.req_addr  = 2'd3;
      if (k == 10) begin bus.req_write = 1'b0; bus.req_addr = 2'd1; end
      if (k == 11) bus.req_valid = 1'b0;
    end
    chk("hold_ready", 32'(m_rdy), 32'h0400);
    chk("hold_busy", 32'(m_busy), 32'h0BFE);
    wait_done(d0 + 1);
    busy_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    chk("hold_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("hold_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("hold_no_third", 32'(busy_seen), 32'd0);

    // Reset in the middle of a two-beat write.
    push_exp(1'b1, 4'd2, 16'h1234);
    @(negedge clk);
    issue(1'b1, 2'd3, 4'd2);
    repeat (5) @(negedge clk);
    chk("mid_wr_low", 32'(bus.otg_wr_n), 32'd0);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_cs_n", 32'(bus.otg_cs_n), 32'd1);
    chk("mrst_wr_n", 32'(bus.otg_wr_n), 32'd1);
    chk("mrst_oe", 32'(bus.otg_data_oe), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wr_src.delete();
    exp_wr.delete();
    repeat (20) @(negedge clk);
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mrst_idle", 32'(bus.busy), 32'd0);

`ifdef HPI_BEAT_COUNT_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("bc_reset", beat_count, 32'd0);
    run_burst(1'b1, 2'd0, 4'd3, 16'h4000, 3);
    run_burst(1'b0, 2'd2, 4'd5, 16'h5000, 5);
    chk("bc_total", beat_count, 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
